mem_port_arbiter: RTL

//  Shares the single-port data/instruction memory between the control unit's fetch path (IF state)
//  and its data path (LDUR/STUR in EX0). Fixed-latency memory transactions are sequenced here;
//  the control unit holds a request stable until ack, which doubles as its stall condition.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signal bundle for mem_port_arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_MAX);
  localparam logic [3:0]      LAT_INIT = 4'(MEM_LATENCY);

  logic [1:0]        state_q, state_d;
  logic              owner_fetch_q, owner_fetch_d;
  logic              store_q, store_d;
  logic              half_q, half_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              data_win;
  logic              unused_addr_bits;

  // Accesses are doubleword aligned; only i_addr[2] matters below the dword boundary.
  assign unused_addr_bits = ^{bus.d_addr[2:0], bus.i_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    owner_fetch_d = owner_fetch_q;
    store_d       = store_q;
    half_d        = half_q;
    lat_cnt_d     = lat_cnt_q;
    starve_cnt_d  = starve_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    data_win      = bus.d_req && !(bus.i_req && starve_cnt_q == SC_MAX);

    case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d   = S_BUSY;
          lat_cnt_d = LAT_INIT;
          mem_en_d  = 1'b1;
          if (data_win) begin
            owner_fetch_d = 1'b0;
            store_d       = bus.d_we;
            mem_we_d      = bus.d_we;
            mem_addr_d    = {bus.d_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_d   = bus.d_wdata;
            starve_cnt_d  = bus.i_req ? starve_cnt_q + 1'b1 : '0;
          end else begin
            owner_fetch_d = 1'b1;
            store_d       = 1'b0;
            half_d        = bus.i_addr[2];
            mem_addr_d    = {bus.i_addr[ADDR_W-1:3], 3'b000};
            starve_cnt_d  = '0;
          end
        end
      end
      S_BUSY: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        // Read data is valid exactly in the BUSY cycle where the count reaches zero.
        if (lat_cnt_q == 4'd0) begin
          state_d   = S_RESP;
          lat_cnt_d = 4'd0;
          if (owner_fetch_q) begin
            i_ack_d   = 1'b1;
            i_rdata_d = half_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
          end else begin
            d_ack_d = 1'b1;
            if (!store_q) d_rdata_d = bus.mem_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_fetch_q <= 1'b0;
      store_q       <= 1'b0;
      half_q        <= 1'b0;
      lat_cnt_q     <= '0;
      starve_cnt_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      store_q       <= store_d;
      half_q        <= half_d;
      lat_cnt_q     <= lat_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
endmodule
